// File: rtl/driver_motor_paso.sv
`default_nettype none
// ============================================================================
// Module      : driver_motor_paso
// Description : Full-step stepper motor driver. Steps at a prescaled tick rate
//               in the commanded direction, holds torque while stopped, waits
//               a programmable number of ticks on direction reversal, and
//               refuses to step past 0 or POS_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module driver_motor_paso #(
    parameter int          PRESCALE    = 50000,
    parameter int          DWELL_TICKS = 4,
    parameter logic [15:0] POS_MAX     = 16'd3600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mover,
    output logic [3:0]  bobinas,
    output logic [15:0] pos_actual,
    output logic        paso,
    output logic        ocupado,
    output logic        limite
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_RUN_CW  = 2'd1;
    localparam logic [1:0]  c_RUN_CCW = 2'd2;
    localparam logic [1:0]  c_DWELL   = 2'd3;

    localparam logic [15:0] c_PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  c_DWELL_INIT = 8'(DWELL_TICKS);

    logic [1:0]  r_mover_q;
    logic [1:0]  r_state;
    logic [15:0] r_presc;
    logic [7:0]  r_dwell;
    logic [1:0]  r_phase;
    logic [3:0]  r_bobinas;
    logic [15:0] r_pos;
    logic        r_paso;
    logic        r_limite;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_presc_nxt;
    logic [7:0]  w_dwell_nxt;
    logic [1:0]  w_phase_nxt;
    logic [3:0]  w_bobinas_nxt;
    logic [15:0] w_pos_nxt;
    logic        w_paso_nxt;
    logic        w_limite_nxt;
    logic        w_tick;
    logic        w_cw;
    logic        w_ccw;

    // The invalid code 10 falls through both decodes and so behaves as stop.
    assign w_cw    = (r_mover_q == 2'b01);
    assign w_ccw   = (r_mover_q == 2'b11);
    assign w_tick  = (r_state != c_IDLE) && (r_presc == c_PRESC_LAST);

    assign bobinas    = r_bobinas;
    assign pos_actual = r_pos;
    assign paso       = r_paso;
    assign limite     = r_limite;
    assign ocupado    = (r_state != c_IDLE);

    // State register and all registered outputs; reset is immediate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mover_q <= 2'b00;
            r_state   <= c_IDLE;
            r_presc   <= 16'd0;
            r_dwell   <= 8'd0;
            r_phase   <= 2'd0;
            r_bobinas <= 4'b1000;
            r_pos     <= 16'd0;
            r_paso    <= 1'b0;
            r_limite  <= 1'b0;
        end else begin
            r_mover_q <= mover;
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_dwell   <= w_dwell_nxt;
            r_phase   <= w_phase_nxt;
            r_bobinas <= w_bobinas_nxt;
            r_pos     <= w_pos_nxt;
            r_paso    <= w_paso_nxt;
            r_limite  <= w_limite_nxt;
        end
    end

    // Next-state, prescaler, position/phase stepping and limit handling.
    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = (r_state == c_IDLE) ? 16'd0 :
                       (w_tick ? 16'd0 : r_presc + 16'd1);
        w_dwell_nxt  = r_dwell;
        w_phase_nxt  = r_phase;
        w_pos_nxt    = r_pos;
        w_paso_nxt   = 1'b0;
        w_limite_nxt = r_limite;

        case (r_state)
            c_IDLE: begin
                w_limite_nxt = 1'b0;
                if (w_cw) begin
                    w_state_nxt = c_RUN_CW;
                end else if (w_ccw) begin
                    w_state_nxt = c_RUN_CCW;
                end
            end
            c_RUN_CW: begin
                if (w_tick) begin
                    if (w_cw) begin
                        if (r_pos >= POS_MAX) begin
                            w_limite_nxt = 1'b1;
                        end else begin
                            w_pos_nxt    = r_pos + 16'd1;
                            w_phase_nxt  = r_phase + 2'd1;
                            w_paso_nxt   = 1'b1;
                            w_limite_nxt = 1'b0;
                        end
                    end else if (w_ccw) begin
                        w_state_nxt = c_DWELL;
                        w_dwell_nxt = c_DWELL_INIT;
                    end else begin
                        w_state_nxt  = c_IDLE;
                        w_limite_nxt = 1'b0;
                    end
                end
            end
            c_RUN_CCW: begin
                if (w_tick) begin
                    if (w_ccw) begin
                        if (r_pos == 16'd0) begin
                            w_limite_nxt = 1'b1;
                        end else begin
                            w_pos_nxt    = r_pos - 16'd1;
                            w_phase_nxt  = r_phase - 2'd1;
                            w_paso_nxt   = 1'b1;
                            w_limite_nxt = 1'b0;
                        end
                    end else if (w_cw) begin
                        w_state_nxt = c_DWELL;
                        w_dwell_nxt = c_DWELL_INIT;
                    end else begin
                        w_state_nxt  = c_IDLE;
                        w_limite_nxt = 1'b0;
                    end
                end
            end
            c_DWELL: begin
                if (w_tick) begin
                    w_dwell_nxt = r_dwell - 8'd1;
                    if (r_dwell == 8'd1) begin
                        if (w_cw) begin
                            w_state_nxt = c_RUN_CW;
                        end else if (w_ccw) begin
                            w_state_nxt = c_RUN_CCW;
                        end else begin
                            w_state_nxt  = c_IDLE;
                            w_limite_nxt = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        // One-hot coil pattern walks right as the phase index rises.
        w_bobinas_nxt = 4'b1000 >> w_phase_nxt;
    end

endmodule
`default_nettype wire

// File: tb/tb_driver_motor_paso.sv
`default_nettype none
// ============================================================================
// Module      : tb_driver_motor_paso
// Description : Self-checking bench for driver_motor_paso. Two instances run
//               side by side: one with POS_MAX=100, one with POS_MAX=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_driver_motor_paso;

    localparam int P  = 4;
    localparam int DW = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  mover_a, mover_b;
    logic [3:0]  bob_a, bob_b;
    logic [15:0] pos_a, pos_b;
    logic        paso_a, paso_b, ocup_a, ocup_b, lim_a, lim_b;

    int total = 0;
    int bad   = 0;

    driver_motor_paso #(.PRESCALE(P), .DWELL_TICKS(DW), .POS_MAX(16'd100)) dut_a (
        .clk(clk), .rst(rst), .mover(mover_a), .bobinas(bob_a),
        .pos_actual(pos_a), .paso(paso_a), .ocupado(ocup_a), .limite(lim_a)
    );

    driver_motor_paso #(.PRESCALE(P), .DWELL_TICKS(DW), .POS_MAX(16'd3)) dut_b (
        .clk(clk), .rst(rst), .mover(mover_b), .bobinas(bob_b),
        .pos_actual(pos_b), .paso(paso_b), .ocupado(ocup_b), .limite(lim_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 stopped, 1 running cw, 2 running ccw, 3 dwelling
    int pmax [2] = '{100, 3};
    int m_mode [2];
    int m_clk  [2];   // clocks elapsed in the current tick period
    int m_dl   [2];   // dwell ticks remaining
    int m_pos  [2];
    int m_paso [2];
    int m_lim  [2];
    int m_mq   [2];   // command as seen one clock late

    task automatic model_reset(input int k);
        m_mode[k] = 0; m_clk[k] = 0; m_dl[k] = 0; m_pos[k] = 0;
        m_paso[k] = 0; m_lim[k] = 0; m_mq[k] = 0;
    endtask

    task automatic model_step(input int k, input int mv);
        int want;
        int dir;
        int np;
        bit tick;
        want = (m_mq[k] == 1) ? 1 : (m_mq[k] == 3) ? -1 : 0;
        m_paso[k] = 0;
        if (m_mode[k] == 0) begin
            m_clk[k] = 0;
            m_lim[k] = 0;
            if (want == 1)  m_mode[k] = 1;
            if (want == -1) m_mode[k] = 2;
        end else begin
            tick = (m_clk[k] == P - 1);
            m_clk[k] = (m_clk[k] + 1) % P;
            if (tick) begin
                if (m_mode[k] == 3) begin
                    if (m_dl[k] == 1) begin
                        m_mode[k] = (want == 1) ? 1 : (want == -1) ? 2 : 0;
                        if (want == 0) m_lim[k] = 0;
                    end
                    m_dl[k] = m_dl[k] - 1;
                end else begin
                    dir = (m_mode[k] == 1) ? 1 : -1;
                    if (want == dir) begin
                        np = m_pos[k] + dir;
                        if (np < 0 || np > pmax[k]) m_lim[k] = 1;
                        else begin
                            m_pos[k] = np; m_paso[k] = 1; m_lim[k] = 0;
                        end
                    end else if (want == 0) begin
                        m_mode[k] = 0; m_lim[k] = 0;
                    end else begin
                        m_mode[k] = 3; m_dl[k] = DW;
                    end
                end
            end
        end
        m_mq[k] = mv;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, int'(mover_a));
            model_step(1, int'(mover_b));
        end
    end

    task automatic compare_one(input int k, input logic [15:0] pos, input logic [3:0] bob,
                               input logic ps, input logic oc, input logic lm);
        string s;
        s = (k == 0) ? "a" : "b";
        check({"pos_", s},  int'(pos), m_pos[k]);
        check({"bob_", s},  int'(bob), 8 >> (m_pos[k] % 4));
        check({"paso_", s}, int'(ps),  m_paso[k]);
        check({"ocup_", s}, int'(oc),  (m_mode[k] != 0) ? 1 : 0);
        check({"lim_", s},  int'(lm),  m_lim[k]);
    endtask

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        compare_one(0, pos_a, bob_a, paso_a, ocup_a, lim_a);
        compare_one(1, pos_b, bob_b, paso_b, ocup_b, lim_b);
    end

    // ---------------- directed helpers ----------------
    task automatic wait_paso_a(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (paso_a) return;
        end
        total++; bad++;
        $display("FAIL paso_a_timeout: got none expected pulse");
        n = -1;
    endtask

    task automatic sync_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int n;
        int ok;
        rst = 1'b1; mover_a = 2'b00; mover_b = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("rst_pos", int'(pos_a), 0);
        check("rst_bob", int'(bob_a), 4'b1000);
        check("rst_ocup", int'(ocup_a), 0);

        // first step latency
        @(negedge clk); mover_a = 2'b01;
        wait_paso_a(n);
        check("latency", n, 6);
        check("lat_pos", int'(pos_a), 1);
        check("lat_bob", int'(bob_a), 4'b0100);

        // four more steps, one every 4 clocks
        for (int i = 0; i < 4; i++) begin
            wait_paso_a(n);
            check("step_period", n, 4);
        end
        check("run_pos", int'(pos_a), 5);
        check("run_bob", int'(bob_a), 4'b0100);
        check("run_ocup", int'(ocup_a), 1);

        // reversal: one tick to notice, two dwell ticks, one tick to step
        @(negedge clk); mover_a = 2'b11;
        wait_paso_a(n);
        check("reversal_gap", n, 16);
        check("rev_pos", int'(pos_a), 4);
        check("rev_bob", int'(bob_a), 4'b1000);

        // run cw up to 7, then asynchronous reset between edges
        sync_reset();
        mover_a = 2'b01;
        for (int i = 0; i < 7; i++) wait_paso_a(n);
        check("pre_rst_pos", int'(pos_a), 7);
        @(posedge clk);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        check("async_pos", int'(pos_a), 0);
        check("async_bob", int'(bob_a), 4'b1000);
        check("async_ocup", int'(ocup_a), 0);
        #1 rst = 1'b0;
        wait_paso_a(n);
        check("resume_latency", n, 6);
        check("resume_pos", int'(pos_a), 1);
        @(negedge clk); mover_a = 2'b00;

        // upper limit on instance b (POS_MAX=3)
        sync_reset();
        mover_b = 2'b01;
        repeat (18) @(posedge clk);
        #1;
        check("lim_hi_pos", int'(pos_b), 3);
        check("lim_hi_flag", int'(lim_b), 1);
        check("lim_hi_paso", int'(paso_b), 0);
        @(negedge clk); mover_b = 2'b10;
        ok = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (!ocup_b) begin ok = 1; break; end
        end
        check("stop_idle", ok, 1);
        check("stop_lim", int'(lim_b), 0);

        // lower limit from position 0
        sync_reset();
        mover_b = 2'b11;
        repeat (6) @(posedge clk);
        #1;
        check("lim_lo_pos", int'(pos_b), 0);
        check("lim_lo_flag", int'(lim_b), 1);
        check("lim_lo_bob", int'(bob_b), 4'b1000);
        @(negedge clk); mover_b = 2'b10;
        repeat (8) @(posedge clk);
        #1;
        check("inv_ocup", int'(ocup_b), 0);
        check("inv_lim", int'(lim_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
